// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Detects load-use hazards (ID vs. load in EX) and control redirects
//   (taken branch / jump resolved in EX), sequences multi-cycle bubbles and
//   flushes, and keeps saturating debug counters of bubble cycles and
//   redirect events.
//
// Ports:
//   clk, reset          clock (posedge) and synchronous active-high reset
//   ifid_rs, ifid_rt    source register fields of the instruction in ID
//   ifid_uses_rt        ID instruction reads rt as a source
//   idex_rt             load destination of the instruction in EX
//   idex_memread        EX instruction is a load
//   ex_branch_taken     EX branch resolved taken
//   ex_jump             EX jump
//   pc_write            PC update enable
//   ifid_write          IF/ID load enable
//   ifid_flush          zero IF/ID
//   idex_stall          insert bubble into ID/EX
//   idex_flush          zero ID/EX
//   stall_count         bubble cycles since reset (saturating)
//   flush_count         redirect events since reset (saturating)
//
// Outputs are Mealy so that ID/EX, which captures on negedge, sees them
// within the same cycle as the hazard inputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; evaluates redirect, then load-use hazard
// LU_STALL | holding PC/IF-ID and bubbling ID/EX; remain cycles left
// FLUSH    | holding IF/ID and ID/EX flush after a redirect; remain left

module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       remain_q, remain_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             inc_stall, inc_flush;

  logic redirect;
  logic lu_hazard;

  assign redirect  = ex_branch_taken | ex_jump;
  assign lu_hazard = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (redirect) begin
      // A redirect wins in every state: the hazardous or stalled instruction
      // is on the wrong path and gets flushed, so no bubble is needed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      inc_flush  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d  = FLUSH;
        remain_d = FLUSH_RELOAD;
      end else begin
        state_d  = RUN;
        remain_d = 4'd0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_stall = 1'b1;
            inc_stall  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d  = LU_STALL;
              remain_d = STALL_RELOAD;
            end
          end
        end
        LU_STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_stall = 1'b1;
          inc_stall  = 1'b1;
          remain_d   = remain_q - 4'd1;
          if (remain_q == 4'd1) state_d = RUN;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          remain_d   = remain_q - 4'd1;
          if (remain_q == 4'd1) state_d = RUN;
        end
        default: begin
          state_d  = RUN;
          remain_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      remain_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (inc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (inc_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances with different parameter
// sets share one stimulus; each scenario resets all of them and checks only
// the instance it targets. Output vectors are {pc_write, ifid_write,
// ifid_flush, idex_stall, idex_flush}.

module tb_hazard_ctrl;

  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11101;
  localparam logic [4:0] O_RST   = 5'b00101;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread, ex_branch_taken, ex_jump;

  logic        a_pc, a_iw, a_if, a_is, a_ifl;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_iw, b_if, b_is, b_ifl;
  logic [15:0] b_sc, b_fc;
  logic        c_pc, c_iw, c_if, c_is, c_ifl;
  logic [1:0]  c_sc, c_fc;

  logic [4:0] a_o, b_o, c_o;
  assign a_o = {a_pc, a_iw, a_if, a_is, a_ifl};
  assign b_o = {b_pc, b_iw, b_if, b_is, b_ifl};
  assign c_o = {c_pc, c_iw, c_if, c_is, c_ifl};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(a_pc), .ifid_write(a_iw), .ifid_flush(a_if), .idex_stall(a_is),
    .idex_flush(a_ifl), .stall_count(a_sc), .flush_count(a_fc));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(b_pc), .ifid_write(b_iw), .ifid_flush(b_if), .idex_stall(b_is),
    .idex_flush(b_ifl), .stall_count(b_sc), .flush_count(b_fc));

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(c_pc), .ifid_write(c_iw), .ifid_flush(c_if), .idex_stall(c_is),
    .idex_flush(c_ifl), .stall_count(c_sc), .flush_count(c_fc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled 2 time units later, well before the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_rt = 5'd0; idex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_jump = 1'b0;
  endtask

  task automatic hazard(input logic [4:0] rt, input logic [4:0] rs);
    idex_memread = 1'b1; idex_rt = rt; ifid_rs = rs;
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b1; idle();
    cyc(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset held two cycles, then released.
    cyc(); #2 check("rst_out_1", 32'(a_o), 32'(O_RST));
    cyc(); #2 check("rst_out_2", 32'(a_o), 32'(O_RST));
    cyc(); reset = 1'b0;
    #2 check("post_rst_out", 32'(a_o), 32'(O_NORM));
    check("post_rst_scnt", 32'(a_sc), 32'd0);
    check("post_rst_fcnt", 32'(a_fc), 32'd0);

    // Load-use on rs, single bubble.
    cyc(); hazard(5'd5, 5'd5);
    #2 check("lu_rs_out", 32'(a_o), 32'(O_STALL));
    cyc(); idle();
    #2 check("lu_rs_next", 32'(a_o), 32'(O_NORM));
    check("lu_rs_scnt", 32'(a_sc), 32'd1);

    // Load into r0 is never a hazard.
    cyc(); hazard(5'd0, 5'd0);
    #2 check("lu_r0_out", 32'(a_o), 32'(O_NORM));
    cyc(); idle();
    #2 check("lu_r0_scnt", 32'(a_sc), 32'd1);

    // rt match only counts when ID actually reads rt.
    cyc(); hazard(5'd7, 5'd3); ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
    #2 check("lu_rt_unused", 32'(a_o), 32'(O_NORM));
    cyc(); ifid_uses_rt = 1'b1;
    #2 check("lu_rt_used", 32'(a_o), 32'(O_STALL));
    cyc(); idle();
    #2 check("lu_rt_next", 32'(a_o), 32'(O_NORM));
    check("lu_rt_scnt", 32'(a_sc), 32'd2);

    // Same-cycle branch and load-use: redirect wins.
    do_reset();
    cyc(); hazard(5'd9, 5'd9); ex_branch_taken = 1'b1;
    #2 check("br_lu_out", 32'(a_o), 32'(O_FLUSH));
    cyc(); idle();
    #2 check("br_lu_next", 32'(a_o), 32'(O_NORM));
    check("br_lu_fcnt", 32'(a_fc), 32'd1);
    check("br_lu_scnt", 32'(a_sc), 32'd0);

    // Three-cycle stall runs to completion; hazard inputs not re-evaluated.
    do_reset();
    cyc(); hazard(5'd4, 5'd4);
    #2 check("ls3_c1", 32'(b_o), 32'(O_STALL));
    cyc(); idle();
    #2 check("ls3_c2", 32'(b_o), 32'(O_STALL));
    cyc(); #2 check("ls3_c3", 32'(b_o), 32'(O_STALL));
    cyc(); #2 check("ls3_done", 32'(b_o), 32'(O_NORM));
    check("ls3_scnt", 32'(b_sc), 32'd3);

    // Jump on the second stall cycle aborts the stall.
    do_reset();
    cyc(); hazard(5'd6, 5'd6);
    #2 check("ls3j_c1", 32'(b_o), 32'(O_STALL));
    cyc(); idle(); ex_jump = 1'b1;
    #2 check("ls3j_c2", 32'(b_o), 32'(O_FLUSH));
    cyc(); idle();
    #2 check("ls3j_c3", 32'(b_o), 32'(O_NORM));
    check("ls3j_scnt", 32'(b_sc), 32'd1);
    check("ls3j_fcnt", 32'(b_fc), 32'd1);
    cyc(); #2 check("ls3j_run", 32'(b_o), 32'(O_NORM));

    // Four redirects 5 cycles apart, 3 flush cycles each, 2-bit counter.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cyc(); ex_branch_taken = 1'b1;
      #2 check("fl3_c1", 32'(c_o), 32'(O_FLUSH));
      cyc(); ex_branch_taken = 1'b0;
      if (p == 0) hazard(5'd2, 5'd2);
      #2 check("fl3_c2", 32'(c_o), 32'(O_FLUSH));
      cyc(); idle();
      #2 check("fl3_c3", 32'(c_o), 32'(O_FLUSH));
      cyc(); #2 check("fl3_done", 32'(c_o), 32'(O_NORM));
      check("fl3_fcnt", 32'(c_fc), (p < 3) ? 32'(p + 1) : 32'd3);
      cyc(); #2 check("fl3_idle", 32'(c_o), 32'(O_NORM));
    end
    check("fl3_scnt", 32'(c_sc), 32'd0);

    // Redirect during FLUSH restarts the hold.
    cyc(); ex_branch_taken = 1'b1;
    #2 check("flr_c1", 32'(c_o), 32'(O_FLUSH));
    cyc(); ex_branch_taken = 1'b0;
    cyc(); ex_jump = 1'b1;
    #2 check("flr_c3", 32'(c_o), 32'(O_FLUSH));
    cyc(); ex_jump = 1'b0;
    #2 check("flr_c4", 32'(c_o), 32'(O_FLUSH));
    cyc(); #2 check("flr_c5", 32'(c_o), 32'(O_FLUSH));
    cyc(); #2 check("flr_done", 32'(c_o), 32'(O_NORM));

    // Reset mid-FLUSH aborts the sequence.
    cyc(); ex_branch_taken = 1'b1;
    #2 check("flx_c1", 32'(c_o), 32'(O_FLUSH));
    cyc(); ex_branch_taken = 1'b0; reset = 1'b1;
    #2 check("flx_rst", 32'(c_o), 32'(O_RST));
    cyc(); reset = 1'b0;
    #2 check("flx_run", 32'(c_o), 32'(O_NORM));
    check("flx_fcnt", 32'(c_fc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
